// File: rtl/hash_request_frontend.sv
// hash_request_frontend: buffers host hash-table requests in a FIFO and issues them under an outstanding-credit limit
// Ports:
//   clock, reset                       posedge clock, synchronous active-high reset
//   s_valid/s_ready, s_opcode/s_key/s_wr_data   host request handshake and payload
//   ht_input_valid, ht_opcode/ht_key/ht_wr_data registered issue strobe and payload to the hash table
//   ht_output_valid                    hash table response strobe, returns one credit
//   fifo_count, outstanding            FIFO occupancy and in-flight request count
//   credit_underflow                   sticky: response seen with nothing outstanding
module hash_request_frontend #(
  parameter int KEY_WIDTH = 32,
  parameter int VAL_WIDTH = 32,
  parameter int NUM_OPCODES = 16,
  parameter int FIFO_DEPTH = 16,
  parameter int MAX_OUTSTANDING = 64,
  localparam int OPCODE_WIDTH = $clog2(NUM_OPCODES),
  localparam int CW = $clog2(FIFO_DEPTH + 1),
  localparam int OW = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [OPCODE_WIDTH-1:0] s_opcode,
  input  logic [KEY_WIDTH-1:0]    s_key,
  input  logic [VAL_WIDTH-1:0]    s_wr_data,
  output logic                    ht_input_valid,
  output logic [OPCODE_WIDTH-1:0] ht_opcode,
  output logic [KEY_WIDTH-1:0]    ht_key,
  output logic [VAL_WIDTH-1:0]    ht_wr_data,
  input  logic                    ht_output_valid,
  output logic [CW-1:0]           fifo_count,
  output logic [OW-1:0]           outstanding,
  output logic                    credit_underflow
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int EW = OPCODE_WIDTH + KEY_WIDTH + VAL_WIDTH;
  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic push, issue, credit;
  assign s_ready = fifo_count < CW'(FIFO_DEPTH);
  assign push = s_valid && s_ready;
  assign issue = (fifo_count != '0) && (outstanding < OW'(MAX_OUTSTANDING));
  // a response only returns a credit if there is one to return (or one is taken this cycle)
  assign credit = ht_output_valid && (issue || outstanding != '0);
  always_ff @(posedge clock)
    if (push) mem[wr_ptr] <= {s_opcode, s_key, s_wr_data};
  always_ff @(posedge clock)
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fifo_count <= '0;
      outstanding <= '0;
      credit_underflow <= 1'b0;
      ht_input_valid <= 1'b0;
      {ht_opcode, ht_key, ht_wr_data} <= '0;
    end else begin
      wr_ptr <= wr_ptr + PW'(push);
      rd_ptr <= rd_ptr + PW'(issue);
      fifo_count <= fifo_count + CW'(push) - CW'(issue);
      outstanding <= outstanding + OW'(issue) - OW'(credit);
      credit_underflow <= credit_underflow || (ht_output_valid && !credit);
      ht_input_valid <= issue;
      {ht_opcode, ht_key, ht_wr_data} <= issue ? mem[rd_ptr] : '0;
    end
endmodule

// File: tb/tb_hash_request_frontend.sv
// tb_hash_request_frontend: directed checks of the request frontend with FIFO_DEPTH 16 and MAX_OUTSTANDING 4
module tb_hash_request_frontend;
  logic clock = 1'b0, reset = 1'b1;
  logic s_valid, s_ready, ht_input_valid, ht_output_valid, credit_underflow;
  logic [3:0] s_opcode, ht_opcode;
  logic [31:0] s_key, s_wr_data, ht_key, ht_wr_data;
  logic [4:0] fifo_count;
  logic [2:0] outstanding;
  int checks = 0, errors = 0, issued = 0, acc = 0;
  logic [67:0] q[$];
  hash_request_frontend #(.FIFO_DEPTH(16), .MAX_OUTSTANDING(4)) dut (
    .clock(clock), .reset(reset), .s_valid(s_valid), .s_ready(s_ready),
    .s_opcode(s_opcode), .s_key(s_key), .s_wr_data(s_wr_data),
    .ht_input_valid(ht_input_valid), .ht_opcode(ht_opcode), .ht_key(ht_key),
    .ht_wr_data(ht_wr_data), .ht_output_valid(ht_output_valid),
    .fifo_count(fifo_count), .outstanding(outstanding), .credit_underflow(credit_underflow)
  );
  always #5 clock = ~clock;
  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    logic [67:0] e;
    if (s_valid && s_ready && !reset) q.push_back({s_opcode, s_key, s_wr_data});
    @(posedge clock);
    #1;
    if (reset) q.delete();
    if (ht_input_valid) begin
      issued++;
      e = (q.size() != 0) ? q.pop_front() : 'x;
      check("issue_order", {ht_opcode, ht_key, ht_wr_data}, e);
    end else check("idle_fields", {ht_opcode, ht_key, ht_wr_data}, 0);
  endtask
  initial begin
    s_valid = 0; s_opcode = 0; s_key = 0; s_wr_data = 0; ht_output_valid = 0;
    tick(); tick();
    reset = 0;
    check("rst_ready", s_ready, 1);
    check("rst_valid", ht_input_valid, 0);
    check("rst_count", fifo_count, 0);
    check("rst_out", outstanding, 0);
    check("rst_uflow", credit_underflow, 0);
    s_valid = 1; s_opcode = 3; s_key = 32'hDEADBEEF; s_wr_data = 32'h1234;
    tick();
    s_valid = 0;
    check("single_count", fifo_count, 1);
    check("single_wait", ht_input_valid, 0);
    tick();
    check("single_valid", ht_input_valid, 1);
    check("single_op", ht_opcode, 3);
    check("single_key", ht_key, 32'hDEADBEEF);
    check("single_data", ht_wr_data, 32'h1234);
    check("single_out1", outstanding, 1);
    tick();
    check("single_pulse", ht_input_valid, 0);
    ht_output_valid = 1;
    tick();
    ht_output_valid = 0;
    check("single_out0", outstanding, 0);
    for (int i = 0; i < 8; i++) begin
      s_valid = 1; s_opcode = 4'(i); s_key = 32'(100 + i); s_wr_data = 32'(3 * i);
      tick();
      check("max_issue", ht_input_valid, (i >= 1 && i <= 4) ? 1 : 0);
    end
    s_valid = 0;
    tick();
    check("max_stall", ht_input_valid, 0);
    check("max_out", outstanding, 4);
    check("max_count", fifo_count, 4);
    for (int i = 0; i < 4; i++) begin
      ht_output_valid = 1;
      tick();
      ht_output_valid = 0;
      check("credit_noissue", ht_input_valid, 0);
      check("credit_out3", outstanding, 3);
      tick();
      check("credit_issue", ht_input_valid, 1);
      check("credit_key", ht_key, 32'(104 + i));
      check("credit_out4", outstanding, 4);
    end
    tick();
    check("credit_stall", ht_input_valid, 0);
    check("credit_empty", fifo_count, 0);
    for (int i = 0; i < 20; i++) begin
      s_valid = 1; s_opcode = 4'(acc); s_key = 32'(300 + acc); s_wr_data = 0;
      if (s_ready) acc++;
      tick();
    end
    check("burst_accepts", acc, 16);
    check("burst_count", fifo_count, 16);
    check("burst_ready", s_ready, 0);
    check("burst_out", outstanding, 4);
    s_opcode = 4'(acc); s_key = 32'(300 + acc);
    ht_output_valid = 1;
    tick();
    check("full_count", fifo_count, 16);
    check("full_out", outstanding, 3);
    tick();
    check("no_bypass_count", fifo_count, 15);
    check("no_bypass_issue", ht_input_valid, 1);
    s_valid = 0;
    for (int i = 0; i < 10; i++) tick();
    check("drain_count", fifo_count, 5);
    check("drain_out", outstanding, 3);
    s_valid = 1;
    tick();
    s_valid = 0;
    check("pushpop_count", fifo_count, 5);
    check("issue_resp_out", outstanding, 3);
    check("pushpop_issue", ht_input_valid, 1);
    ht_output_valid = 0;
    reset = 1;
    tick();
    reset = 0;
    issued = 0;
    for (int i = 0; i < 40; i++) begin
      s_valid = 1; s_opcode = 4'(i); s_key = 32'(i); s_wr_data = 32'(1000 + i);
      tick();
      ht_output_valid = ht_input_valid;
    end
    s_valid = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      ht_output_valid = ht_input_valid;
    end
    check("wrap_issued", issued, 40);
    check("wrap_out", outstanding, 0);
    check("wrap_count", fifo_count, 0);
    check("wrap_uflow", credit_underflow, 0);
    ht_output_valid = 1;
    tick();
    ht_output_valid = 0;
    check("uflow_set", credit_underflow, 1);
    check("uflow_out", outstanding, 0);
    tick(); tick();
    check("uflow_sticky", credit_underflow, 1);
    reset = 1;
    tick();
    reset = 0;
    check("uflow_clear", credit_underflow, 0);
    for (int i = 0; i < 10; i++) begin
      s_valid = 1; s_opcode = 4'(i); s_key = 32'(500 + i); s_wr_data = 32'(i);
      tick();
    end
    s_valid = 0;
    check("mid_count6", fifo_count, 6);
    check("mid_out4", outstanding, 4);
    ht_output_valid = 1;
    tick();
    ht_output_valid = 0;
    check("mid_count", fifo_count, 6);
    check("mid_out3", outstanding, 3);
    reset = 1;
    tick();
    reset = 0;
    check("mid_rst_count", fifo_count, 0);
    check("mid_rst_out", outstanding, 0);
    check("mid_rst_valid", ht_input_valid, 0);
    check("mid_rst_ready", s_ready, 1);
    issued = 0;
    for (int i = 0; i < 5; i++) tick();
    check("mid_no_stale", issued, 0);
    ht_output_valid = 1;
    tick();
    ht_output_valid = 0;
    check("late_resp_uflow", credit_underflow, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/hash_request_frontend.md
# hash_request_frontend

Ingress stage directly upstream of the multi-PE hash table. Accepts lookup/insert/delete requests from the host over a valid/ready handshake and buffers them in a FIFO. Issues at most one request per cycle on the hash table's unthrottled input port. Limits in-flight operations with a credit counter that is returned by the hash table's output-valid pulse, so that a burst cannot exceed a bounded number of outstanding requests.

## Interface
Parameters:
- KEY_WIDTH, 32, key width; matches hash table.
- VAL_WIDTH, 32, write-data width; matches hash table.
- NUM_OPCODES, 16, opcode space; OPCODE_WIDTH = $clog2(NUM_OPCODES).
- FIFO_DEPTH, 16, request buffer entries; power of two, ≥2.
- MAX_OUTSTANDING, 64, maximum issued-but-unanswered requests; ≥1.

Ports:
- clock  in  1  system clock; all logic is posedge.
- reset  in  1  reset, synchronous, active-high.
- s_valid  in  1  host request valid.
- s_ready  out  1  host may transfer; transfer occurs when s_valid && s_ready at a posedge.
- s_opcode  in  OPCODE_WIDTH  request opcode.
- s_key  in  KEY_WIDTH  request key.
- s_wr_data  in  VAL_WIDTH  request write data.
- ht_input_valid  out  1  registered issue strobe to hash table.
- ht_opcode  out  OPCODE_WIDTH  registered opcode to hash table.
- ht_key  out  KEY_WIDTH  registered key to hash table.
- ht_wr_data  out  VAL_WIDTH  registered write data to hash table.
- ht_output_valid  in  1  hash table response strobe; returns one credit.
- fifo_count  out  $clog2(FIFO_DEPTH+1)  current FIFO occupancy.
- outstanding  out  $clog2(MAX_OUTSTANDING+1)  current in-flight count.
- credit_underflow  out  1  sticky error flag: a response arrived with outstanding == 0.

## Operation
- FIFO: circular buffer with read and write pointers of $clog2(FIFO_DEPTH) bits plus an occupancy counter. Pointers wrap modulo FIFO_DEPTH.
- s_ready = (fifo_count < FIFO_DEPTH). It is a combinational function of registered state only and does not depend on s_valid.
- When full, s_ready is 0 even if a pop occurs in the same cycle; there is no full-bypass.
- issue = (fifo_count != 0) && (outstanding < MAX_OUTSTANDING). The check uses the registered outstanding value. A response arriving in the same cycle does not enable an issue.
- On issue:
  - pop the head entry into the ht_* registers;
  - set ht_input_valid = 1.
- Without issue:
  - ht_input_valid = 0;
  - ht_opcode, ht_key and ht_wr_data are driven to 0.
- Simultaneous push and pop: occupancy is unchanged and both pointers advance.
- Empty FIFO: no bypass path. A push is always written before it can be issued.
- Outstanding counter:
  - issue only: +1;
  - ht_output_valid only (with outstanding > 0): −1;
  - both in the same cycle: unchanged.
- ht_output_valid with outstanding == 0 and no issue that cycle: the counter holds at 0 and credit_underflow is set. It stays set until reset.
- The opcode is not interpreted; every value passes through unchanged.
- No request is dropped. Ordering is strict FIFO.
- Reset mid-operation:
  - FIFO contents are discarded;
  - pointers, fifo_count, outstanding, credit_underflow and all ht_* outputs are cleared to 0.
  - Responses to requests issued before reset are not tracked. If they arrive after reset they set credit_underflow.

## Timing
- Reset values: s_ready = 1 from the first cycle after reset deasserts, derived from count 0. ht_input_valid = 0; ht_opcode, ht_key, ht_wr_data = 0; fifo_count = 0; outstanding = 0; credit_underflow = 0.
- Accept-to-issue latency is 2 cycles minimum:
  - a transfer at edge t is written to the FIFO;
  - the issue decision is made in cycle t+1 and registered at edge t+1;
  - ht_input_valid is high during the cycle after edge t+1.
- ht_input_valid is a 1-cycle pulse per request.
- Back-to-back issues occur on every cycle while the FIFO is non-empty and credits are available. Sustained throughput is 1 request/cycle.
- The outstanding counter updates at the same edge that registers the issue. Credit return takes effect at the edge sampling ht_output_valid.

## Test plan
- Reset then single request (opcode 3, key 0xDEADBEEF, data 0x1234):
  - ht_input_valid pulses once, 2 cycles after the transfer, with matching fields;
  - outstanding goes 0→1;
  - one ht_output_valid pulse returns outstanding to 0.
- Burst of 20 pushes with no issue possible (MAX_OUTSTANDING reached):
  - s_ready drops after 16 accepts;
  - fifo_count = 16;
  - 4 requests remain held by the host.
- MAX_OUTSTANDING = 4, 8 queued, no responses:
  - exactly 4 consecutive issues, then stall.
  - Each single response pulse enables exactly one further issue, on the cycle after the credit is registered.
- Simultaneous push/pop at fifo_count = 5, and issue + response in the same cycle:
  - fifo_count stays 5;
  - outstanding is unchanged;
  - ordering is preserved across pointer wrap after 40 sequential keys 0..39.
- ht_output_valid with outstanding = 0:
  - credit_underflow = 1 and stays set;
  - outstanding stays 0;
  - reset clears the flag.
- Reset asserted with 6 queued and 3 outstanding:
  - the next cycle shows all counters 0, ht_input_valid = 0 and s_ready = 1;
  - no stale request is issued afterward.
